// File: rtl/key_load_ctrl_if.sv
// Bundle for the key-load controller: control pulses, serial stream in, committed key and status out.
// The controller owns the slave side; whoever provisions the key drives the master side.
interface key_load_ctrl_if #(
    parameter int KEY_W = 28
);
    logic             start;
    logic             clear;
    logic             ser_valid;
    logic             ser_data;
    logic             ser_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             busy;
    logic             fault;
    logic             lockout;
    logic [3:0]       fail_cnt;

    modport master (
        output start, clear, ser_valid, ser_data,
        input  ser_ready, key_out, key_valid, busy, fault, lockout, fail_cnt
    );

    modport slave (
        input  start, clear, ser_valid, ser_data,
        output ser_ready, key_out, key_valid, busy, fault, lockout, fail_cnt
    );
endinterface

// File: rtl/key_load_ctrl.sv
// Key-provisioning controller for the mux-locked c432 core: serial key + even parity, sticky brute-force lockout.
// Optional inter-beat idle timeout in LOAD is built only when KEYCTRL_TIMEOUT_EN is defined.
module key_load_ctrl #(
    parameter int KEY_W    = 28,
    parameter int MAX_FAIL = 3,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    key_load_ctrl_if.slave   bus
);
    localparam int BEAT_W = $clog2(KEY_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_ARMED,
        S_FAULT,
        S_LOCKOUT
    } state_e;

    if (KEY_W < 1 || MAX_FAIL < 1 || MAX_FAIL > 15 || TIMEOUT < 1) begin : g_param_check
        $error("key_load_ctrl: illegal parameter set");
    end

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   shift_q, shift_d;
    logic               par_q, par_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               key_valid_q, key_valid_d;
    logic               fault_q, fault_d;
    logic [3:0]         fail_q, fail_d;
    logic               beat;
    logic               do_fail;

`ifdef KEYCTRL_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0]  idle_q, idle_d;
`endif

    assign beat = bus.ser_valid && (state_q == S_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            par_q       <= 1'b0;
            beat_q      <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            fail_q      <= '0;
`ifdef KEYCTRL_TIMEOUT_EN
            idle_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            beat_q      <= beat_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            fault_q     <= fault_d;
            fail_q      <= fail_d;
`ifdef KEYCTRL_TIMEOUT_EN
            idle_q      <= idle_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        par_d       = par_q;
        beat_d      = beat_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        fault_d     = fault_q;
        fail_d      = fail_q;
        do_fail     = 1'b0;
`ifdef KEYCTRL_TIMEOUT_EN
        idle_d      = idle_q;
`endif

        if (state_q == S_LOCKOUT) begin
            // Sticky: only rst_n leaves this state.
            state_d = S_LOCKOUT;
        end else if (bus.clear) begin
            state_d     = S_IDLE;
            shift_d     = '0;
            par_d       = 1'b0;
            beat_d      = '0;
            key_d       = '0;
            key_valid_d = 1'b0;
            fault_d     = 1'b0;
`ifdef KEYCTRL_TIMEOUT_EN
            idle_d      = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_ARMED, S_FAULT: begin
                    // Key drops on the same edge the reload starts, so the core never sees a partial key.
                    if (bus.start) begin
                        state_d     = S_LOAD;
                        shift_d     = '0;
                        par_d       = 1'b0;
                        beat_d      = '0;
                        key_d       = '0;
                        key_valid_d = 1'b0;
`ifdef KEYCTRL_TIMEOUT_EN
                        idle_d      = '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        if (beat_q == BEAT_W'(KEY_W)) begin
                            par_d   = bus.ser_data;
                            state_d = S_CHECK;
                        end else begin
                            for (int i = 0; i < KEY_W; i++) begin
                                if (beat_q == BEAT_W'(i)) shift_d[i] = bus.ser_data;
                            end
                            beat_d = beat_q + 1'b1;
                        end
                    end
`ifdef KEYCTRL_TIMEOUT_EN
                    // Fails on the TIMEOUT-th consecutive idle cycle; the counter never passes TIMEOUT-1.
                    if (beat)                                  idle_d  = '0;
                    else if (idle_q >= IDLE_W'(TIMEOUT - 1))   do_fail = 1'b1;
                    else                                       idle_d  = idle_q + 1'b1;
`endif
                end
                S_CHECK: begin
                    if (^{shift_q, par_q} == 1'b0) begin
                        state_d     = S_ARMED;
                        key_d       = shift_q;
                        key_valid_d = 1'b1;
                        fail_d      = '0;
                        fault_d     = 1'b0;
                    end else begin
                        do_fail = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        if (do_fail) begin
            fail_d      = fail_q + 4'd1;
            fault_d     = 1'b1;
            key_d       = '0;
            key_valid_d = 1'b0;
            state_d     = ((fail_q + 4'd1) == 4'(MAX_FAIL)) ? S_LOCKOUT : S_FAULT;
        end
    end

    // Status flags are single-gate decodes of the registered state.
    assign bus.ser_ready = (state_q == S_LOAD);
    assign bus.busy      = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign bus.lockout   = (state_q == S_LOCKOUT);
    assign bus.key_out   = key_q;
    assign bus.key_valid = key_valid_q;
    assign bus.fault     = fault_q;
    assign bus.fail_cnt  = fail_q;
endmodule
